// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared loader/microcontroller state encodings and width defaults
package prog_loader_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_WORD_W = 16;
    localparam int BYTE_W     = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HI    = 3'd1,
        ST_LO    = 3'd2,
        ST_WRITE = 3'd3,
        ST_RUN   = 3'd4
    } ld_state_t;

    // Only the quiescent states (before a load, or with the CPU running) honour start.
    function automatic logic accepts_start(input ld_state_t s);
        return (s == ST_IDLE) || (s == ST_RUN);
    endfunction

endpackage

// File: rtl/addr_cnt.sv
// rtl/addr_cnt.sv - program-memory word counter with clear, enable and natural wrap
module addr_cnt #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clr,
    input  logic              i_en,
    output logic [ADDR_W-1:0] o_count
);

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] r_count;

    // Clear has priority over enable; the top count rolls over to zero on its own.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + ONE;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream program loader that holds the CPU in reset while filling program memory
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int WORD_W = DEF_WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [WORD_W-1:0] wdata,
    output logic              cpu_hold,
    output logic              done
);

    ld_state_t         r_state;
    logic [ADDR_W-1:0] r_len;
    logic [WORD_W-1:0] r_wdata;
    logic              r_byte_ready;
    logic              r_we;
    logic              r_cpu_hold;
    logic              r_done;

    logic [ADDR_W-1:0] w_count;
    logic [ADDR_W-1:0] w_len_m1;
    logic              w_last;
    logic              w_start_ok;
    logic              w_cnt_clr;
    logic              w_cnt_en;

    // len=0 becomes all-ones here, so a zero length naturally covers the whole memory.
    assign w_len_m1   = r_len - ADDR_W'(1);
    assign w_last     = (w_count == w_len_m1);
    assign w_start_ok = start && accepts_start(r_state);
    assign w_cnt_clr  = w_start_ok;
    assign w_cnt_en   = (r_state == ST_WRITE) && !w_last;

    addr_cnt #(
        .ADDR_W (ADDR_W)
    ) u_addr_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cnt_en),
        .o_count (w_count)
    );

    // Load sequencer: assemble two bytes per word, write it, and release the CPU after the last one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_len        <= '0;
            r_wdata      <= '0;
            r_byte_ready <= 1'b0;
            r_we         <= 1'b0;
            r_cpu_hold   <= 1'b1;
            r_done       <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_RUN: begin
                    if (w_start_ok) begin
                        r_state      <= ST_HI;
                        r_len        <= len;
                        r_byte_ready <= 1'b1;
                        r_cpu_hold   <= 1'b1;
                    end
                end
                ST_HI: begin
                    if (byte_valid) begin
                        r_wdata[WORD_W-1 -: BYTE_W] <= byte_data;
                        r_state                     <= ST_LO;
                    end
                end
                ST_LO: begin
                    if (byte_valid) begin
                        r_wdata[BYTE_W-1:0] <= byte_data;
                        r_state             <= ST_WRITE;
                        r_byte_ready        <= 1'b0;
                        r_we                <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (w_last) begin
                        r_state    <= ST_RUN;
                        r_done     <= 1'b1;
                        r_cpu_hold <= 1'b0;
                    end else begin
                        r_state      <= ST_HI;
                        r_byte_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_byte_ready <= 1'b0;
                    r_cpu_hold   <= 1'b1;
                end
            endcase
        end
    end

    assign byte_ready = r_byte_ready;
    assign we         = r_we;
    assign waddr      = w_count;
    assign wdata      = r_wdata;
    assign cpu_hold   = r_cpu_hold;
    assign done       = r_done;

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 10, program-memory address width (matches PC width).
REQ-002 Parameter WORD_W, default 16, instruction width (two bytes).
REQ-003 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 Port reset, input, 1, asynchronous, active-low reset.
REQ-005 Port start, input, 1, one-cycle request to begin a program load.
REQ-006 Port len, input, ADDR_W, word count sampled on accepted start; 0 means 2^ADDR_W words.
REQ-007 Port byte_valid, input, 1, byte_data carries a valid byte.
REQ-008 Port byte_data, input, 8, instruction byte stream, high byte first.
REQ-009 Port byte_ready, output, 1, loader accepts a byte this cycle.
REQ-010 Port we, output, 1, program-memory write enable.
REQ-011 Port waddr, output, ADDR_W, program-memory write address.
REQ-012 Port wdata, output, WORD_W, program-memory write data.
REQ-013 Port cpu_hold, output, 1, active-high; drives the microcontroller's reset while loading.
REQ-014 Port done, output, 1, one-cycle pulse when the last word has been written.

Function
REQ-015 The FSM SHALL have states IDLE, HI, LO, WRITE, RUN.
REQ-016 IDLE and RUN SHALL move to HI on start=1, latching len and clearing the word counter; start SHALL be ignored in HI, LO and WRITE.
REQ-017 byte_ready SHALL be 1 exactly in HI and LO; a byte is accepted only on byte_valid && byte_ready.
REQ-018 HI SHALL store an accepted byte as wdata[15:8] and move to LO; LO SHALL store it as wdata[7:0] and move to WRITE.
REQ-019 byte_valid=0 in HI or LO SHALL hold state and all registers indefinitely (no timeout).
REQ-020 WRITE SHALL last one cycle with we=1, waddr=counter, wdata={hi,lo}; we SHALL be 0 in all other states.
REQ-021 From WRITE, if counter equals len-1 (modulo 2^ADDR_W), the FSM SHALL go to RUN; otherwise it SHALL increment counter and go to HI.
REQ-022 Write latency SHALL be exactly one cycle after the low byte is accepted; peak throughput is one word per three cycles.
REQ-023 The counter SHALL wrap 2^ADDR_W-1 -> 0 without error; len=0 writes all 2^ADDR_W addresses.
REQ-024 done SHALL be 1 only in the first cycle of RUN.
REQ-025 cpu_hold SHALL be 1 in IDLE, HI, LO, WRITE and 0 in RUN; the microcontroller starts at address 0 in the cycle after done.
REQ-026 start in RUN SHALL reassert cpu_hold in the next cycle and restart the load from address 0.

Reset
REQ-027 reset=0 SHALL immediately force IDLE, counter=0, wdata=0, latched len=0, we=0, done=0, byte_ready=0, cpu_hold=1.
REQ-028 Reset mid-load SHALL abandon the load; already-written words are not cleared, and a new start is required.

Structure
REQ-029 Shared include file SHALL hold the state encodings and the ADDR_W/WORD_W defaults, used by both this block and the microcontroller.
REQ-030 The word counter SHALL be a separate sub-module addr_cnt (clear, enable, wrap, ADDR_W wide); the FSM and byte registers remain in prog_loader.

Verification
REQ-031 After reset, with no start -> cpu_hold=1, we=0, byte_ready=0, done=0 for 20 cycles.
REQ-032 start with len=3, bytes 0x04,0x01,0x08,0x02,0x20,0x13 always valid -> writes 0x0401@0, 0x0802@1, 0x2013@2; done one cycle after third we; cpu_hold falls with done.
REQ-033 len=2 with byte_valid toggling every other cycle -> same words written, no extra we pulses, state held while byte_valid=0.
REQ-034 start pulsed during HI and WRITE -> ignored; counter and addresses unchanged.
REQ-035 reset pulsed after 3 bytes of a len=4 load -> cpu_hold=1 and IDLE immediately; a following start with len=1, bytes 0xFC,0x00 -> 0xFC00@0.
REQ-036 len=0 with 2048 bytes -> 1024 writes at addresses 0..1023 in order, single done pulse; a start in RUN reasserts cpu_hold next cycle.
